ps2_mouse_packet_decoder: RTL and testbench

- Sits directly downstream of the PS/2 transceiver (ps2_controller with INITIALIZE_MOUSE=1). Consumes its received_data / received_data_en byte stream.
- Assembles standard 3-byte PS/2 mouse packets and decodes them into button state and signed 9-bit movement deltas.
- Maintains a clamped absolute cursor position for video-side logic.
- Resynchronises on framing errors and inter-byte timeouts.

---
 rtl/ps2_mouse_packet_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_mouse_packet_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder
//
// Purpose:
//   Takes the byte stream from the PS/2 transceiver and builds standard
//   3-byte mouse packets from it. Each packet is decoded into button state
//   and signed 9-bit movement deltas. The decoder also keeps a clamped
//   absolute cursor position for the video logic. It recovers from framing
//   errors and from long gaps between the bytes of one packet.
//
// Ports:
//   CLOCK_50          in   system clock (single domain)
//   reset             in   synchronous, active-high reset
//   received_data     in   [7:0] byte from the PS/2 transceiver
//   received_data_en  in   one-cycle strobe, received_data valid
//   recenter          in   load X_INIT/Y_INIT into the cursor position
//   packet_valid      out  one-cycle pulse, decoded outputs just updated
//   buttons           out  [2:0] {middle, right, left}
//   dx                out  [8:0] two's complement x movement
//   dy                out  [8:0] two's complement y movement
//   overflow          out  x or y overflow flag of the last packet
//   x_pos             out  [POS_W-1:0] clamped cursor x
//   y_pos             out  [POS_W-1:0] clamped cursor y
//   sync_error        out  one-cycle pulse on a discarded byte or timeout

module ps2_mouse_packet_decoder #(
   parameter int X_MAX          = 639,
   parameter int Y_MAX          = 479,
   parameter int X_INIT         = 320,
   parameter int Y_INIT         = 240,
   parameter int POS_W          = 10,
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter bit INVERT_Y       = 1'b1
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [7:0]       received_data,
   input  logic             received_data_en,
   input  logic             recenter,
   output logic             packet_valid,
   output logic [2:0]       buttons,
   output logic [8:0]       dx,
   output logic [8:0]       dy,
   output logic             overflow,
   output logic [POS_W-1:0] x_pos,
   output logic [POS_W-1:0] y_pos,
   output logic             sync_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic signed [POS_W+1:0] X_MAX_S = (POS_W+2)'(X_MAX);
   localparam logic signed [POS_W+1:0] Y_MAX_S = (POS_W+2)'(Y_MAX);
   localparam logic [7:0] ACK_BYTE = 8'hFA;

   typedef enum logic [1:0] {
      WAIT_B0,
      WAIT_B1,
      WAIT_B2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] timeout_cnt;

   // Only the header fields that are used later are kept. Bit 3 is the
   // framing marker and is not needed after the header has been accepted.
   logic [2:0]       btn_q;
   logic             x_sign_q;
   logic             y_sign_q;
   logic             ovf_q;
   logic [7:0]       byte1_q;

   logic [8:0]             dx_next;
   logic [8:0]             dy_next;
   logic signed [POS_W+1:0] dx_ext;
   logic signed [POS_W+1:0] dy_ext;
   logic signed [POS_W+1:0] x_sum;
   logic signed [POS_W+1:0] y_sum;
   logic [POS_W-1:0]       x_next;
   logic [POS_W-1:0]       y_next;

   // Decode the packet and compute the next cursor position. Byte 2 is
   // taken straight from the input bus, so the result is ready on the
   // cycle in which that byte arrives. The sums use two extra bits. The
   // extra bits hold the sign and any overshoot past the screen edge
   // before the value is clamped back into range.
   always_comb begin
      dx_next = {x_sign_q, byte1_q};
      dy_next = {y_sign_q, received_data};
      dx_ext  = {{(POS_W-7){dx_next[8]}}, dx_next};
      dy_ext  = {{(POS_W-7){dy_next[8]}}, dy_next};
      x_sum   = $signed({2'b00, x_pos}) + dx_ext;
      if (INVERT_Y)
         y_sum = $signed({2'b00, y_pos}) - dy_ext;
      else
         y_sum = $signed({2'b00, y_pos}) + dy_ext;

      x_next = x_sum[POS_W-1:0];
      if (x_sum < 0)
         x_next = '0;
      else if (x_sum > X_MAX_S)
         x_next = X_MAX_S[POS_W-1:0];

      y_next = y_sum[POS_W-1:0];
      if (y_sum < 0)
         y_next = '0;
      else if (y_sum > Y_MAX_S)
         y_next = Y_MAX_S[POS_W-1:0];
   end

   // This block holds the packet framing FSM, the inter-byte timeout and
   // the registered outputs. A strobe takes priority over timeout expiry
   // in the same cycle. Recenter is applied after the FSM, so it
   // overrides a position update from a packet that completes in the same
   // cycle. The decoded fields from that packet still update.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state        <= WAIT_B0;
         timeout_cnt  <= '0;
         btn_q        <= '0;
         x_sign_q     <= 1'b0;
         y_sign_q     <= 1'b0;
         ovf_q        <= 1'b0;
         byte1_q      <= '0;
         packet_valid <= 1'b0;
         sync_error   <= 1'b0;
         buttons      <= '0;
         dx           <= '0;
         dy           <= '0;
         overflow     <= 1'b0;
         x_pos        <= POS_W'(X_INIT);
         y_pos        <= POS_W'(Y_INIT);
      end else begin
         packet_valid <= 1'b0;
         sync_error   <= 1'b0;

         case (state)
            WAIT_B0: begin
               timeout_cnt <= '0;
               if (received_data_en) begin
                  if (received_data == ACK_BYTE) begin
                     state <= WAIT_B0;
                  end else if (received_data[3]) begin
                     btn_q    <= received_data[2:0];
                     x_sign_q <= received_data[4];
                     y_sign_q <= received_data[5];
                     ovf_q    <= received_data[6] | received_data[7];
                     state    <= WAIT_B1;
                  end else begin
                     sync_error <= 1'b1;
                  end
               end
            end

            WAIT_B1: begin
               if (received_data_en) begin
                  byte1_q     <= received_data;
                  timeout_cnt <= '0;
                  state       <= WAIT_B2;
               end else if (timeout_cnt == CNT_LAST) begin
                  timeout_cnt <= '0;
                  sync_error  <= 1'b1;
                  state       <= WAIT_B0;
               end else begin
                  timeout_cnt <= timeout_cnt + CNT_W'(1);
               end
            end

            WAIT_B2: begin
               if (received_data_en) begin
                  buttons      <= btn_q;
                  dx           <= dx_next;
                  dy           <= dy_next;
                  overflow     <= ovf_q;
                  packet_valid <= 1'b1;
                  if (!ovf_q) begin
                     x_pos <= x_next;
                     y_pos <= y_next;
                  end
                  timeout_cnt <= '0;
                  state       <= WAIT_B0;
               end else if (timeout_cnt == CNT_LAST) begin
                  timeout_cnt <= '0;
                  sync_error  <= 1'b1;
                  state       <= WAIT_B0;
               end else begin
                  timeout_cnt <= timeout_cnt + CNT_W'(1);
               end
            end

            default: begin
               timeout_cnt <= '0;
               state       <= WAIT_B0;
            end
         endcase

         if (recenter) begin
            x_pos <= POS_W'(X_INIT);
            y_pos <= POS_W'(Y_INIT);
         end
      end
   end

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// tb_ps2_mouse_packet_decoder
//
// Purpose:
//   Directed testbench for ps2_mouse_packet_decoder. The timeout is shortened
//   to 100 cycles. Expected values are hand-computed from the packet bytes.
//
// Ports: none (top-level bench).

module tb_ps2_mouse_packet_decoder;

   logic       CLOCK_50;
   logic       reset;
   logic [7:0] received_data;
   logic       received_data_en;
   logic       recenter;
   logic       packet_valid;
   logic [2:0] buttons;
   logic [8:0] dx;
   logic [8:0] dy;
   logic       overflow;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic       sync_error;

   int errors = 0;
   int checks = 0;
   int sync_count;
   int valid_count;
   int sync_at;

   ps2_mouse_packet_decoder #(
      .TIMEOUT_CYCLES(100)
   ) dut (
      .CLOCK_50        (CLOCK_50),
      .reset           (reset),
      .received_data   (received_data),
      .received_data_en(received_data_en),
      .recenter        (recenter),
      .packet_valid    (packet_valid),
      .buttons         (buttons),
      .dx              (dx),
      .dy              (dy),
      .overflow        (overflow),
      .x_pos           (x_pos),
      .y_pos           (y_pos),
      .sync_error      (sync_error)
   );

   // 50 MHz clock
   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, actual, actual, expected, expected);
      end
   endtask

   // Present one byte (optionally with recenter) for exactly one clock.
   // Returns 1 time unit after the edge that consumed it.
   task automatic applyStimulus(input logic [7:0] b, input logic rc = 1'b0);
      @(negedge CLOCK_50);
      received_data    = b;
      received_data_en = 1'b1;
      recenter         = rc;
      @(posedge CLOCK_50);
      #1;
      received_data_en = 1'b0;
      recenter         = 1'b0;
   endtask

   // One-cycle recenter pulse
   task automatic pulseRecenter();
      @(negedge CLOCK_50);
      recenter = 1'b1;
      @(posedge CLOCK_50);
      #1;
      recenter = 1'b0;
   endtask

   // Idle for n cycles and count the sync_error and packet_valid pulses
   task automatic idleCycles(input int n);
      sync_count  = 0;
      valid_count = 0;
      sync_at     = -1;
      for (int i = 1; i <= n; i++) begin
         @(posedge CLOCK_50);
         #1;
         if (sync_error) begin
            sync_count++;
            sync_at = i;
         end
         if (packet_valid) valid_count++;
      end
   endtask

   initial begin
      reset            = 1'b1;
      received_data    = 8'h00;
      received_data_en = 1'b0;
      recenter         = 1'b0;

      // Reset state
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      @(posedge CLOCK_50);
      #1;
      checkOutput("rst_x", 32'(x_pos), 32'd320);
      checkOutput("rst_y", 32'(y_pos), 32'd240);
      checkOutput("rst_dx", 32'(dx), 32'd0);
      checkOutput("rst_dy", 32'(dy), 32'd0);
      checkOutput("rst_btn", 32'(buttons), 32'd0);
      checkOutput("rst_ovf", 32'(overflow), 32'd0);
      checkOutput("rst_valid", 32'(packet_valid), 32'd0);
      checkOutput("rst_sync", 32'(sync_error), 32'd0);

      // Positive move
      applyStimulus(8'h09);
      applyStimulus(8'h05);
      checkOutput("pos_novalid_b1", 32'(packet_valid), 32'd0);
      applyStimulus(8'h03);
      checkOutput("pos_valid", 32'(packet_valid), 32'd1);
      checkOutput("pos_btn", 32'(buttons), 32'd1);
      checkOutput("pos_dx", 32'(dx), 32'd5);
      checkOutput("pos_dy", 32'(dy), 32'd3);
      checkOutput("pos_x", 32'(x_pos), 32'd325);
      checkOutput("pos_y", 32'(y_pos), 32'd237);
      @(posedge CLOCK_50);
      #1;
      checkOutput("pos_valid_pulse", 32'(packet_valid), 32'd0);
      checkOutput("pos_dx_hold", 32'(dx), 32'd5);

      // Recenter, then a negative move
      pulseRecenter();
      checkOutput("rc_x", 32'(x_pos), 32'd320);
      checkOutput("rc_y", 32'(y_pos), 32'd240);
      applyStimulus(8'h38);
      applyStimulus(8'hFB);
      applyStimulus(8'hFE);
      checkOutput("neg_valid", 32'(packet_valid), 32'd1);
      checkOutput("neg_btn", 32'(buttons), 32'd0);
      checkOutput("neg_dx", 32'(dx), 32'h1FB);
      checkOutput("neg_dy", 32'(dy), 32'h1FE);
      checkOutput("neg_x", 32'(x_pos), 32'd315);
      checkOutput("neg_y", 32'(y_pos), 32'd242);

      // Clamp at the right edge
      pulseRecenter();
      applyStimulus(8'h08); applyStimulus(8'hFF); applyStimulus(8'h00);
      checkOutput("clamp1_x", 32'(x_pos), 32'd575);
      checkOutput("clamp1_dx", 32'(dx), 32'd255);
      applyStimulus(8'h08); applyStimulus(8'hFF); applyStimulus(8'h00);
      checkOutput("clamp2_x", 32'(x_pos), 32'd639);
      applyStimulus(8'h08); applyStimulus(8'hFF); applyStimulus(8'h00);
      checkOutput("clamp3_x", 32'(x_pos), 32'd639);
      checkOutput("clamp3_y", 32'(y_pos), 32'd240);

      // Overflow packet: the fields update but the position does not
      applyStimulus(8'h48); applyStimulus(8'h10); applyStimulus(8'h10);
      checkOutput("ovf_valid", 32'(packet_valid), 32'd1);
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
      checkOutput("ovf_dx", 32'(dx), 32'd16);
      checkOutput("ovf_x", 32'(x_pos), 32'd639);
      checkOutput("ovf_y", 32'(y_pos), 32'd240);

      // Resync: an ACK is ignored, a byte with bit 3 clear is rejected
      applyStimulus(8'hFA);
      checkOutput("ack_sync", 32'(sync_error), 32'd0);
      checkOutput("ack_valid", 32'(packet_valid), 32'd0);
      applyStimulus(8'h00);
      checkOutput("bad_sync", 32'(sync_error), 32'd1);
      applyStimulus(8'h0A); applyStimulus(8'h01); applyStimulus(8'h01);
      checkOutput("resync_valid", 32'(packet_valid), 32'd1);
      checkOutput("resync_btn", 32'(buttons), 32'd2);
      checkOutput("resync_dx", 32'(dx), 32'd1);
      checkOutput("resync_dy", 32'(dy), 32'd1);
      checkOutput("resync_ovf", 32'(overflow), 32'd0);
      checkOutput("resync_x", 32'(x_pos), 32'd639);
      checkOutput("resync_y", 32'(y_pos), 32'd239);

      // Timeout after two bytes of a packet
      applyStimulus(8'h08);
      applyStimulus(8'h01);
      idleCycles(100);
      checkOutput("to_sync_count", 32'(sync_count), 32'd1);
      checkOutput("to_sync_cycle", 32'(sync_at), 32'd100);
      checkOutput("to_valid_count", 32'(valid_count), 32'd0);
      applyStimulus(8'h09); applyStimulus(8'h02); applyStimulus(8'h02);
      checkOutput("fresh_valid", 32'(packet_valid), 32'd1);
      checkOutput("fresh_btn", 32'(buttons), 32'd1);
      checkOutput("fresh_dx", 32'(dx), 32'd2);
      checkOutput("fresh_y", 32'(y_pos), 32'd237);

      // A strobe on the expiry cycle wins over the timeout
      applyStimulus(8'h08);
      applyStimulus(8'h01);
      idleCycles(99);
      checkOutput("exp_idle_sync", 32'(sync_count), 32'd0);
      applyStimulus(8'h03);
      checkOutput("exp_sync", 32'(sync_error), 32'd0);
      checkOutput("exp_valid", 32'(packet_valid), 32'd1);
      checkOutput("exp_dx", 32'(dx), 32'd1);
      checkOutput("exp_dy", 32'(dy), 32'd3);
      checkOutput("exp_y", 32'(y_pos), 32'd234);

      // Recenter coincident with packet completion: recenter wins for the
      // position, but the decoded fields still update
      applyStimulus(8'h09);
      applyStimulus(8'h05);
      applyStimulus(8'h07, 1'b1);
      checkOutput("rcpkt_valid", 32'(packet_valid), 32'd1);
      checkOutput("rcpkt_dx", 32'(dx), 32'd5);
      checkOutput("rcpkt_dy", 32'(dy), 32'd7);
      checkOutput("rcpkt_x", 32'(x_pos), 32'd320);
      checkOutput("rcpkt_y", 32'(y_pos), 32'd240);

      // A reset in the middle of a packet discards the partial packet
      applyStimulus(8'h09);
      @(negedge CLOCK_50);
      reset = 1'b1;
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
      checkOutput("mid_rst_dx", 32'(dx), 32'd0);
      applyStimulus(8'h00);
      checkOutput("mid_rst_sync", 32'(sync_error), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
